// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one burst memory port between the camera write
// stream and the VGA read stream of a 1024x768 RGB565 frame buffer.
// Reads are favoured to keep the display fed, but at most MAX_RD_RUN reads
// in a row are granted while a write burst is waiting.
//
// Optional feature: define FB_PINGPONG_EN to double-buffer between
// FB0_BASE and FB1_BASE. Without it both streams use FB0_BASE.
`timescale 1ns/1ps

module fb_port_arbiter #(
    parameter int unsigned BURST_LEN   = 256,
    parameter int unsigned FRAME_WORDS = 786432,
    parameter int unsigned RD_LOW      = 256,
    parameter int unsigned MAX_RD_RUN  = 4,
    parameter logic [23:0] FB0_BASE    = 24'h000000,
    parameter logic [23:0] FB1_BASE    = 24'h100000
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [9:0]  wr_fifo_level,
    input  logic [9:0]  rd_fifo_level,
    input  logic        cam_frame_start,
    input  logic        vga_frame_start,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_done,
    output logic        grant_wr,
    output logic        grant_rd,
    output logic        rd_starve
);

    // Offsets are word offsets inside one frame buffer.
    localparam int unsigned OFF_W = 20;
    localparam int unsigned RUN_W = $clog2(MAX_RD_RUN + 1);

    // One extra bit so "offset + burst" can reach FRAME_WORDS exactly.
    localparam logic [OFF_W:0]   BURST_EXT = (OFF_W + 1)'(BURST_LEN);
    localparam logic [OFF_W:0]   FRAME_EXT = (OFF_W + 1)'(FRAME_WORDS);
    localparam logic [RUN_W-1:0] MAX_RUN   = RUN_W'(MAX_RD_RUN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t            state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [23:0]       mem_addr_q;

    logic [OFF_W-1:0]  wr_off_q, wr_off_d;
    logic [OFF_W-1:0]  rd_off_q, rd_off_d;
    logic              rd_hold_q, rd_hold_d;
    logic [RUN_W-1:0]  rd_run_q, rd_run_d;
    logic              rd_starve_q, rd_starve_d;

    logic              rd_need;
    logic              wr_need;
    logic              pick_rd;
    logic              pick_wr;
    logic              xfer_done;
    logic [OFF_W:0]    wr_sum;
    logic [OFF_W:0]    rd_sum;

    logic              wr_bank;
    logic              rd_bank;
    logic [23:0]       wr_base;
    logic [23:0]       rd_base;
    logic [23:0]       wr_addr;
    logic [23:0]       rd_addr;

    // ------------------------------------------------------------------
    // Bank selection
    // ------------------------------------------------------------------
`ifdef FB_PINGPONG_EN
    logic wr_bank_q, wr_bank_d;
    logic rd_bank_q, rd_bank_d;

    // Camera flips to the other bank each frame; the display picks up the
    // bank the camera has just finished, i.e. the one it is not writing.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path leaves it unassigned and a latch is never inferred.
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (cam_frame_start) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (vga_frame_start) begin
            rd_bank_d = ~wr_bank_d;
        end
    end

    // Bank registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    assign wr_bank = wr_bank_q;
    assign rd_bank = rd_bank_q;
`else
    // Single buffer: both streams live in FB0.
    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
`endif

    assign wr_base = wr_bank ? FB1_BASE : FB0_BASE;
    assign rd_base = rd_bank ? FB1_BASE : FB0_BASE;

    // 24-bit add; any carry out of bit 23 is dropped.
    assign wr_addr = wr_base + {{(24 - OFF_W){1'b0}}, wr_off_q};
    assign rd_addr = rd_base + {{(24 - OFF_W){1'b0}}, rd_off_q};

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign rd_need = ({22'd0, rd_fifo_level} <= RD_LOW) && !rd_hold_q;
    assign wr_need = ({22'd0, wr_fifo_level} >= BURST_LEN);

    // Reads win unless they have already used up their run allowance.
    assign pick_rd = rd_need && (!wr_need || (rd_run_q != MAX_RUN));
    assign pick_wr = wr_need && !pick_rd;

    assign xfer_done = (state_q == XFER) && mem_done;

    // Port FSM with registered request outputs; ack/done are only looked
    // at in the state that expects them.
    always_ff @(posedge CLK or negedge RSTn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!RSTn) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_rd || pick_wr) begin
                        state_q    <= REQ;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= pick_wr;
                        mem_addr_q <= pick_wr ? wr_addr : rd_addr;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state_q   <= XFER;
                        mem_req_q <= 1'b0;
                    end
                end
                XFER: begin
                    if (mem_done) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Grants steer the datapath from the accepting cycle through the done
    // cycle, so they decode the FSM state rather than wait a clock.
    assign grant_wr = mem_we_q &&
                      (((state_q == REQ) && mem_ack) || (state_q == XFER));
    assign grant_rd = !mem_we_q &&
                      (((state_q == REQ) && mem_ack) || (state_q == XFER));

    // ------------------------------------------------------------------
    // Frame offsets, read hold, read-run counter, starvation flag
    // ------------------------------------------------------------------
    assign wr_sum = {1'b0, wr_off_q} + BURST_EXT;
    assign rd_sum = {1'b0, rd_off_q} + BURST_EXT;

    // Advance offsets on burst completion; frame starts override the
    // advance so a burst finishing in the same cycle cannot skip a frame.
    always_comb begin
        wr_off_d  = wr_off_q;
        rd_off_d  = rd_off_q;
        rd_hold_d = rd_hold_q;
        if (xfer_done && mem_we_q) begin
            wr_off_d = (wr_sum == FRAME_EXT) ? '0 : wr_sum[OFF_W-1:0];
        end
        if (xfer_done && !mem_we_q) begin
            if (rd_sum == FRAME_EXT) begin
                rd_off_d  = '0;
                rd_hold_d = 1'b1;
            end else begin
                rd_off_d = rd_sum[OFF_W-1:0];
            end
        end
        if (cam_frame_start) begin
            wr_off_d = '0;
        end
        if (vga_frame_start) begin
            rd_off_d  = '0;
            rd_hold_d = 1'b0;
        end
    end

    // Count back-to-back reads taken while a write waits; any write grant,
    // or an idle cycle with no write demand, restarts the count.
    always_comb begin
        rd_run_d = rd_run_q;
        if (state_q == IDLE) begin
            if (pick_wr || !wr_need) begin
                rd_run_d = '0;
            end else if (pick_rd && (rd_run_q != MAX_RUN)) begin
                rd_run_d = rd_run_q + 1'b1;
            end
        end
    end

    // Starvation: the display FIFO ran dry part-way through a frame.
    assign rd_starve_d = rd_starve_q ||
                         ((rd_fifo_level == '0) && !rd_hold_q && (rd_off_q != '0));

    // Bookkeeping registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_off_q    <= '0;
            rd_off_q    <= '0;
            rd_hold_q   <= 1'b1;
            rd_run_q    <= '0;
            rd_starve_q <= 1'b0;
        end else begin
            wr_off_q    <= wr_off_d;
            rd_off_q    <= rd_off_d;
            rd_hold_q   <= rd_hold_d;
            rd_run_q    <= rd_run_d;
            rd_starve_q <= rd_starve_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign rd_starve = rd_starve_q;

    // ------------------------------------------------------------------
    // Interface invariants
    // ------------------------------------------------------------------
    // A pending request keeps its attributes until it is accepted.
    a_req_stable: assert property (@(posedge CLK) disable iff (!RSTn)
        (mem_req && !mem_ack) |=> (mem_req && $stable(mem_we) && $stable(mem_addr)));

    // Only one direction owns the datapath at a time.
    a_grant_onehot: assert property (@(posedge CLK) disable iff (!RSTn)
        !(grant_wr && grant_rd));

endmodule
